oven_entry_ctrl: RTL and testbench
==================================

# oven_entry_ctrl

Front-end controller for the oven simulator. It accepts BCD key digits and enter/cancel pulses, assembles them into the 10-bit binary setpoint temperature and bake time, and range-checks both values. It sequences the 2-bit oven state consumed by the baking block. It also echoes the digits being typed as three BCD display digits for the seven-segment drivers. It performs the reverse of the baking block's binary-to-digit split: BCD digits in, binary out.

## Interface
Clock is `clk`; reset `rst` is asynchronous and active-high.

Parameters:
- TEMP_MIN, 150, lowest accepted setpoint (°F)
- TEMP_MAX, 550, highest accepted setpoint (°F)
- TIME_MIN, 1, shortest accepted bake time (s)
- TIME_MAX, 999, longest accepted bake time (s)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- digit_in  in  4  key digit value, sampled when digit_valid=1
- digit_valid  in  1  one-cycle pulse, debounced upstream
- enter  in  1  one-cycle pulse, commit current entry
- cancel  in  1  one-cycle pulse, abort to temperature entry
- state  out  2  0=TEMP_ENTRY, 1=TIME_ENTRY, 2=BAKE, 3=FAULT
- inputTemp  out  10  committed setpoint, binary
- timerVal  out  10  committed bake time in seconds, binary
- dispVal0, dispVal1, dispVal2  out  4 each  BCD echo of typed digits (ones/tens/hundreds)
- entry_error  out  1  high while in FAULT

## Operation
- All outputs are registered. Reset values: state=0, inputTemp=65, timerVal=0, dispVal0..2=0, entry_error=0, internal digit count=0.
- Event priority in any cycle: cancel > enter > digit_valid. Lower-priority events in the same cycle are dropped.
- Digit entry is accepted only in TEMP_ENTRY and TIME_ENTRY:
  - digit_in > 9 is ignored.
  - A valid digit shifts left into the display (dispVal2←dispVal1, dispVal1←dispVal0, dispVal0←digit) and increments the count, which saturates at 3.
  - A 4th and any later digit is ignored; the display holds.
- Enter handling in the two entry states:
  - With count=0, enter is ignored.
  - Otherwise value = dispVal2·100 + dispVal1·10 + dispVal0, range 0..999, computed in 10 bits with no overflow.
  - TEMP_ENTRY: if TEMP_MIN ≤ value ≤ TEMP_MAX, load inputTemp, go to TIME_ENTRY, clear digits and count. Otherwise go to FAULT.
  - TIME_ENTRY: if TIME_MIN ≤ value ≤ TIME_MAX, load timerVal, go to BAKE, clear digits and count. Otherwise go to FAULT.
- BAKE: inputTemp and timerVal are held stable. Digits and enter are ignored.
- FAULT: entry_error=1. Digits and enter are ignored. The display keeps the offending digits.
- Cancel, from any state: go to TEMP_ENTRY, clear digits, count and entry_error.
  - inputTemp returns to 65 and timerVal to 0 only when cancel is taken from BAKE or FAULT.
  - Cancel taken from TIME_ENTRY keeps the committed inputTemp until it is overwritten.
- Reset asserted mid-entry or mid-bake forces all reset values immediately.

## Timing
- digit_valid in cycle N: dispVal0..2 update at edge N+1.
- enter in cycle N: state, inputTemp/timerVal, entry_error and the cleared display all update together at edge N+1. Single-cycle latency, no handshake.
- cancel in cycle N: all affected outputs update at edge N+1.
- Back-to-back pulses on consecutive cycles are all honoured.
- Inputs are synchronous to clk; no internal synchronizers.

## Structure
- Shared package `oven_pkg` holds:
  - state encodings ST_TEMP_ENTRY=0, ST_TIME_ENTRY=1, ST_BAKE=2, ST_FAULT=3; the baking block's "state==2" uses ST_BAKE.
  - AMBIENT_TEMP=65.
  - default limits 150/550/1/999.
- One sub-module, `bcd3_to_bin`: combinational, three 4-bit BCD digits in, 10-bit binary out. Multiply by 10 as (x<<3)+(x<<1) and by 100 as (x<<6)+(x<<5)+(x<<2).
- The FSM, digit shifter and range checks live in oven_entry_ctrl.

## Test plan
- Reset, then digits 3,5,0 and enter → inputTemp=350, state=1. Then digits 1,2,0 and enter → timerVal=120, state=2, display 0,0,0.
- Digits 1,2,3,4 → display shows 1,2,3 (4th digit ignored). Enter in TEMP_ENTRY → 123<150, so state=3, entry_error=1.
- In FAULT, pulse digits and enter → no change. Cancel → state=0, inputTemp=65, timerVal=0, entry_error=0.
- digit_in=12 with digit_valid → ignored. Enter with no digits → ignored, state stays 0.
- Same-cycle enter+digit with digits 4,0,0 typed → inputTemp=400, digit dropped. Same-cycle cancel+enter in TIME_ENTRY → state=0.
- Assert rst while in BAKE with inputTemp=500 → state=0, inputTemp=65 immediately, before the next clk edge.

Source files
------------

// File: rtl/oven_pkg.sv
// Shared oven encodings, ambient temperature and default entry limits.
// Latency: none (constants and types only).
// Backpressure: none.
package oven_pkg;

    typedef enum logic [1:0] {
        ST_TEMP_ENTRY = 2'd0,
        ST_TIME_ENTRY = 2'd1,
        ST_BAKE       = 2'd2,
        ST_FAULT      = 2'd3
    } oven_state_t;

    localparam logic [9:0] AMBIENT_TEMP = 10'd65;

    localparam logic [9:0] DEF_TEMP_MIN = 10'd150;
    localparam logic [9:0] DEF_TEMP_MAX = 10'd550;
    localparam logic [9:0] DEF_TIME_MIN = 10'd1;
    localparam logic [9:0] DEF_TIME_MAX = 10'd999;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [1:0] MAX_DIGITS   = 2'd3;

endpackage

// File: rtl/bcd3_to_bin.sv
// Converts three BCD digits (hundreds/tens/ones) to a 10-bit binary value.
// Latency: combinational.
// Backpressure: none.
module bcd3_to_bin (
    input  logic [3:0] bcd_hund,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_ones,
    output logic [9:0] bin_out
);

    logic [9:0] hund_w;
    logic [9:0] tens_w;
    logic [9:0] ones_w;

    // Shift-and-add: x*100 = x*64 + x*32 + x*4, x*10 = x*8 + x*2; 9*100+99 fits in 10 bits.
    always_comb begin
        hund_w  = {6'd0, bcd_hund};
        tens_w  = {6'd0, bcd_tens};
        ones_w  = {6'd0, bcd_ones};
        bin_out = (hund_w << 6) + (hund_w << 5) + (hund_w << 2)
                + (tens_w << 3) + (tens_w << 1)
                + ones_w;
    end

endmodule

// File: rtl/oven_entry_ctrl.sv
// Keypad entry FSM: assembles BCD digits into setpoint and bake time, range-checks, sequences oven state.
// Latency: every pulse (digit/enter/cancel) in cycle N is reflected on the registered outputs at edge N+1.
// Backpressure: none; each cycle's highest-priority pulse (cancel > enter > digit) is taken, others dropped.
module oven_entry_ctrl
    import oven_pkg::*;
#(
    parameter logic [9:0] TEMP_MIN = DEF_TEMP_MIN,
    parameter logic [9:0] TEMP_MAX = DEF_TEMP_MAX,
    parameter logic [9:0] TIME_MIN = DEF_TIME_MIN,
    parameter logic [9:0] TIME_MAX = DEF_TIME_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       enter,
    input  logic       cancel,
    output logic [1:0] state,
    output logic [9:0] inputTemp,
    output logic [9:0] timerVal,
    output logic [3:0] dispVal0,
    output logic [3:0] dispVal1,
    output logic [3:0] dispVal2,
    output logic       entry_error
);

    oven_state_t state_q, state_d;
    logic [9:0]  temp_q, temp_d;
    logic [9:0]  timer_q, timer_d;
    logic [3:0]  disp0_q, disp0_d;
    logic [3:0]  disp1_q, disp1_d;
    logic [3:0]  disp2_q, disp2_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [9:0]  entry_value;
    logic        in_entry;
    logic        temp_ok;
    logic        time_ok;

    // The displayed digits are always the value that enter would commit.
    bcd3_to_bin u_bcd3_to_bin (
        .bcd_hund (disp2_q),
        .bcd_tens (disp1_q),
        .bcd_ones (disp0_q),
        .bin_out  (entry_value)
    );

    // Range checks against the committed-value limits.
    always_comb begin
        in_entry = (state_q == ST_TEMP_ENTRY) || (state_q == ST_TIME_ENTRY);
        temp_ok  = (entry_value >= TEMP_MIN) && (entry_value <= TEMP_MAX);
        time_ok  = (entry_value >= TIME_MIN) && (entry_value <= TIME_MAX);
    end

    // Next-state decode with cancel > enter > digit priority.
    always_comb begin
        state_d = state_q;
        temp_d  = temp_q;
        timer_d = timer_q;
        disp0_d = disp0_q;
        disp1_d = disp1_q;
        disp2_d = disp2_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (cancel) begin
            state_d = ST_TEMP_ENTRY;
            disp0_d = 4'd0;
            disp1_d = 4'd0;
            disp2_d = 4'd0;
            cnt_d   = 2'd0;
            err_d   = 1'b0;
            // A committed setpoint survives a cancel out of time entry only.
            if (state_q == ST_BAKE || state_q == ST_FAULT) begin
                temp_d  = AMBIENT_TEMP;
                timer_d = 10'd0;
            end
        end else if (enter) begin
            if (in_entry && cnt_q != 2'd0) begin
                if (state_q == ST_TEMP_ENTRY ? temp_ok : time_ok) begin
                    if (state_q == ST_TEMP_ENTRY) begin
                        temp_d  = entry_value;
                        state_d = ST_TIME_ENTRY;
                    end else begin
                        timer_d = entry_value;
                        state_d = ST_BAKE;
                    end
                    disp0_d = 4'd0;
                    disp1_d = 4'd0;
                    disp2_d = 4'd0;
                    cnt_d   = 2'd0;
                end else begin
                    // Offending digits stay on the display for the user.
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                end
            end
        end else if (digit_valid) begin
            if (in_entry && digit_in <= BCD_MAX && cnt_q < MAX_DIGITS) begin
                disp2_d = disp1_q;
                disp1_d = disp0_q;
                disp0_d = digit_in;
                cnt_d   = cnt_q + 2'd1;
            end
        end
    end

    // State and output registers; reset restores ambient idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_TEMP_ENTRY;
            temp_q  <= AMBIENT_TEMP;
            timer_q <= 10'd0;
            disp0_q <= 4'd0;
            disp1_q <= 4'd0;
            disp2_q <= 4'd0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            temp_q  <= temp_d;
            timer_q <= timer_d;
            disp0_q <= disp0_d;
            disp1_q <= disp1_d;
            disp2_q <= disp2_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign state       = state_q;
    assign inputTemp   = temp_q;
    assign timerVal    = timer_q;
    assign dispVal0    = disp0_q;
    assign dispVal1    = disp1_q;
    assign dispVal2    = disp2_q;
    assign entry_error = err_q;

endmodule

// File: tb/tb_oven_entry_ctrl.sv
// Directed bench for oven_entry_ctrl with hand-computed expectations.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: none.
module tb_oven_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit_in = 4'd0;
    logic       digit_valid = 1'b0;
    logic       enter = 1'b0;
    logic       cancel = 1'b0;
    logic [1:0] state;
    logic [9:0] inputTemp;
    logic [9:0] timerVal;
    logic [3:0] dispVal0;
    logic [3:0] dispVal1;
    logic [3:0] dispVal2;
    logic       entry_error;

    int vectors = 0;
    int miscompares = 0;

    oven_entry_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .enter       (enter),
        .cancel      (cancel),
        .state       (state),
        .inputTemp   (inputTemp),
        .timerVal    (timerVal),
        .dispVal0    (dispVal0),
        .dispVal1    (dispVal1),
        .dispVal2    (dispVal2),
        .entry_error (entry_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input int h, input int t, input int o);
        chk({tag, ".d2"}, int'(dispVal2), h);
        chk({tag, ".d1"}, int'(dispVal1), t);
        chk({tag, ".d0"}, int'(dispVal0), o);
    endtask

    task automatic chk_core(input string tag, input int st, input int tmp, input int tmr, input int err);
        chk({tag, ".state"}, int'(state), st);
        chk({tag, ".temp"},  int'(inputTemp), tmp);
        chk({tag, ".timer"}, int'(timerVal), tmr);
        chk({tag, ".err"},   int'(entry_error), err);
    endtask

    // One cycle of stimulus, released 1 ns after the edge that samples it.
    task automatic step(input logic [3:0] d, input logic dv, input logic en, input logic cn);
        digit_in    = d;
        digit_valid = dv;
        enter       = en;
        cancel      = cn;
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        enter       = 1'b0;
        cancel      = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        step(d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic keys3(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        key(h);
        key(t);
        key(o);
    endtask

    task automatic press_enter();
        step(4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic press_cancel();
        step(4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_core("reset", 0, 65, 0, 0);
        chk_disp("reset", 0, 0, 0);
        rst = 1'b0;

        // Temperature 350, then time 120
        keys3(4'd3, 4'd5, 4'd0);
        chk_disp("type350", 3, 5, 0);
        chk("type350.state", int'(state), 0);
        press_enter();
        chk_core("commit350", 1, 350, 0, 0);
        chk_disp("commit350", 0, 0, 0);
        keys3(4'd1, 4'd2, 4'd0);
        chk_disp("type120", 1, 2, 0);
        press_enter();
        chk_core("commit120", 2, 350, 120, 0);
        chk_disp("commit120", 0, 0, 0);

        // BAKE ignores digits and enter
        key(4'd7);
        chk_disp("bake_digit", 0, 0, 0);
        press_enter();
        chk_core("bake_enter", 2, 350, 120, 0);

        // Cancel from BAKE restores ambient
        press_cancel();
        chk_core("cancel_bake", 0, 65, 0, 0);

        // Fourth digit ignored; 123 below minimum faults
        keys3(4'd1, 4'd2, 4'd3);
        key(4'd4);
        chk_disp("fourth_digit", 1, 2, 3);
        press_enter();
        chk_core("fault123", 3, 65, 0, 1);
        chk_disp("fault123", 1, 2, 3);

        // FAULT ignores digits and enter
        key(4'd5);
        press_enter();
        chk_core("fault_hold", 3, 65, 0, 1);
        chk_disp("fault_hold", 1, 2, 3);

        press_cancel();
        chk_core("cancel_fault", 0, 65, 0, 0);
        chk_disp("cancel_fault", 0, 0, 0);

        // Non-BCD digit and empty enter are ignored
        key(4'd12);
        chk_disp("digit12", 0, 0, 0);
        press_enter();
        chk_core("empty_enter", 0, 65, 0, 0);

        // Enter wins over a same-cycle digit
        keys3(4'd4, 4'd0, 4'd0);
        step(4'd7, 1'b1, 1'b1, 1'b0);
        chk_core("enter_digit", 1, 400, 0, 0);
        chk_disp("enter_digit", 0, 0, 0);

        // Cancel wins over enter in TIME_ENTRY; setpoint kept
        key(4'd5);
        step(4'd0, 1'b0, 1'b1, 1'b1);
        chk_core("cancel_enter", 0, 400, 0, 0);
        chk_disp("cancel_enter", 0, 0, 0);

        // Temperature boundaries 149 / 150, time 0 faults
        keys3(4'd1, 4'd4, 4'd9);
        press_enter();
        chk_core("temp149", 3, 400, 0, 1);
        press_cancel();
        chk_core("cancel149", 0, 65, 0, 0);
        keys3(4'd1, 4'd5, 4'd0);
        press_enter();
        chk_core("temp150", 1, 150, 0, 0);
        key(4'd0);
        press_enter();
        chk_core("time0", 3, 150, 0, 1);
        chk_disp("time0", 0, 0, 0);
        press_cancel();

        // Upper boundaries 550 and 999
        keys3(4'd5, 4'd5, 4'd0);
        press_enter();
        chk_core("temp550", 1, 550, 0, 0);
        keys3(4'd9, 4'd9, 4'd9);
        press_enter();
        chk_core("time999", 2, 550, 999, 0);
        press_cancel();
        keys3(4'd5, 4'd5, 4'd1);
        press_enter();
        chk_core("temp551", 3, 65, 0, 1);
        press_cancel();

        // Short entries: "5","0","0" -> 500, "1" -> time 1
        keys3(4'd5, 4'd0, 4'd0);
        press_enter();
        key(4'd1);
        press_enter();
        chk_core("bake500", 2, 500, 1, 0);

        // Asynchronous reset mid-bake, observed before the next edge
        #2;
        rst = 1'b1;
        #1;
        chk_core("async_rst", 0, 65, 0, 0);
        chk_disp("async_rst", 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
